encoder_8to3_pending: RTL and testbench
=======================================

# encoder_8to3_pending

Sequential 8-to-3 request encoder, the inverse of the 3-to-8 one-hot decoder used in the select/enable datapath. Collects one-hot or multi-hot request pulses into a sticky pending register. Presents the index of the winning request as a 3-bit binary code under a valid/ready handshake, and clears each bit once it has been accepted. Sits between interrupt/request sources and any consumer that drives a 3-to-8 decoder's `select` input.

## Interface

Parameters:
- none; width fixed at 8 requests / 3-bit index.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst_n` in 1 — reset, synchronous, active-low.
- `enable` in 1 — high: `req` is captured into pending; low: `req` is ignored, but existing pending bits still drain.
- `req` in 8 — request pulses; bit i requests index i; any number of bits may be set per cycle.
- `idx` out 3 — binary index of the granted request; meaningful only while `valid`=1.
- `valid` out 1 — `idx` holds an unaccepted grant.
- `ready` in 1 — consumer accepts `idx` when `valid`&&`ready` at a rising edge.
- `pending` out 8 — current sticky request register (registered).

## Operation

- Register update each edge: `pending <= (pending & ~clr) | (enable ? req : 8'h00)`.
  - `clr` is the one-hot of `idx` when `valid`&&`ready`, else 0.
  - A new `req` bit arriving in the same cycle its index is accepted wins: the bit stays pending.
- Winner selection:
  - Combinational over `avail = pending & ~clr`.
  - Fixed priority: lowest set bit wins (bit 0 highest).
- FSM, two states:
  - IDLE (`valid`=0):
    - if `pending`≠0: load `idx` <= winner(pending), `valid` <= 1 → HOLD.
    - else stay IDLE.
  - HOLD (`valid`=1):
    - `idx` and `valid` held stable while `ready`=0.
    - On handshake with `avail`≠0: load the next winner in the same edge, stay HOLD (back-to-back grants, one per cycle).
    - On handshake with `avail`=0: `valid` <= 0 → IDLE.
- Index bit stays in `pending` until accepted; `pending` shows outstanding work including the bit currently presented.
- Requests for an already-pending index merge (no counting, no overflow).
- `enable` low never drops `valid` or clears `pending`.

## Timing

- Reset values: `idx`=3'b000, `valid`=0, `pending`=8'h00, FSM=IDLE. Round-robin pointer = 3'b111 (so bit 0 wins first).
- Reset is synchronous. Asserting `rst_n`=0 mid-HOLD drops `valid` at the next edge without a handshake; pending requests are discarded.
- Latency: `req` sampled at edge N → `pending` set after N → `valid`/`idx` after edge N+1 (2 cycles) when IDLE.
- Throughput: 1 grant per cycle with `ready` held high.
- `idx` changes only on an edge where FSM enters HOLD or a handshake occurs.
- No combinational path from `req`/`enable` to any output. `ready` affects outputs only through registers.

## Configuration

- `ENCODER_ROUND_ROBIN_EN` defined:
  - Winner is the first set bit of `avail` scanning upward from (last accepted index + 1), wrapping 7→0.
  - Pointer updates only on handshake.
- Not defined: fixed lowest-index priority; no pointer register.

## Test plan

- Reset then idle: `rst_n`=0 two cycles, `req`=0 → `valid`=0, `idx`=0, `pending`=8'h00 throughout.
- Single request: `enable`=1, `req`=8'h20 one cycle, `ready`=1 → `valid`=1, `idx`=3'd5 two edges later for one cycle, then `pending`=8'h00, `valid`=0.
- Multi-hot burst: `req`=8'hA5 one cycle, `ready`=1 → `idx` sequence 0,2,5,7 on consecutive cycles. With the macro defined, the sequence is the same from reset pointer. After a prior grant of 5, the same burst yields 7,0,2,5.
- Backpressure: `req`=8'h0C, `ready`=0 for 5 cycles → `idx`=2 stable, `valid`=1; release `ready` → 2 then 3.
- Re-request on accept: `idx`=4 presented, `req`=8'h10 in the handshake cycle → bit 4 remains in `pending`, `idx`=4 presented again next cycle.
- Enable/reset corners:
  - `enable`=0 with `req`=8'hFF → `pending` unchanged.
  - `rst_n`=0 while `valid`=1, `pending`=8'h06 → next edge `valid`=0, `pending`=8'h00.

Source files
------------

// File: rtl/encoder_8to3_pending.sv
// ---------------------------------------------------------------------------
// encoder_8to3_pending
//
// Sequential 8-to-3 request encoder. Request pulses are OR-ed into a sticky
// pending register. The index of the winning pending bit is presented as a
// 3-bit binary code under a valid/ready handshake. A bit is cleared from
// pending only when its index is accepted. This is the inverse of the 3-to-8
// one-hot decoder that usually sits downstream on the select input.
//
// Optional feature macro: ENCODER_ROUND_ROBIN_EN
//   undefined (default) : fixed priority, lowest set bit wins, no pointer.
//   defined             : round-robin, scan upward from last accepted + 1,
//                         wrapping 7 -> 0; pointer resets to 3'b111 so that
//                         bit 0 wins first after reset.
//
// Ports
//   clk      in   1  single clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   enable   in   1  1: capture req into pending; 0: ignore req (drain only)
//   req      in   8  request pulses, bit i requests index i, multi-hot ok
//   idx      out  3  granted index, meaningful while valid = 1
//   valid    out  1  idx holds an unaccepted grant
//   ready    in   1  consumer accepts idx when valid && ready at an edge
//   pending  out  8  sticky request register, includes the presented bit
//
// All outputs come straight from flops; req, enable and ready reach outputs
// only through registers.
// ---------------------------------------------------------------------------
module encoder_8to3_pending (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic [7:0] pending_q, pending_d;

  logic       hs_s;
  logic [7:0] clr_s;
  logic [7:0] avail_s;
  logic [2:0] win_idle_s;
  logic [2:0] win_hold_s;

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;

  // First set bit of a, scanning upward from last + 1 and wrapping 7 -> 0.
  // k = 8 wraps back to last itself, so a lone bit at last is still found.
  function automatic logic [2:0] winner_rr(input logic [7:0] a,
                                           input logic [2:0] last);
    logic [2:0] w;
    logic [2:0] cand;
    logic       found;
    w     = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = last + k[2:0];
      if (!found && a[cand]) begin
        w     = cand;
        found = 1'b1;
      end else begin
        w     = w;
      end
    end
    return w;
  endfunction
`else
  // Lowest set bit of a; scanning downward lets the lowest bit overwrite.
  function automatic logic [2:0] winner_fixed(input logic [7:0] a);
    logic [2:0] w;
    w = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (a[i]) begin
        w = i[2:0];
      end else begin
        w = w;
      end
    end
    return w;
  endfunction
`endif

  // Handshake, accepted-bit clear mask and the masked request vector.
  always_comb begin
    hs_s    = valid_q & ready;
    clr_s   = hs_s ? (8'd1 << idx_q) : 8'd0;
    avail_s = pending_q & ~clr_s;
    // A request landing on the index being accepted survives the clear.
    pending_d = avail_s | (enable ? req : 8'h00);
  end

  // Winner candidates: from IDLE the whole pending vector is eligible; on a
  // handshake the accepted bit is excluded and the scan restarts after it.
  always_comb begin
`ifdef ENCODER_ROUND_ROBIN_EN
    win_idle_s = winner_rr(pending_q, ptr_q);
    win_hold_s = winner_rr(avail_s, idx_q);
`else
    win_idle_s = winner_fixed(pending_q);
    win_hold_s = winner_fixed(avail_s);
`endif
  end

  // Grant FSM next-state and output-register next values.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
`ifdef ENCODER_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pending_q != 8'h00) begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
          idx_d   = win_idle_s;
        end else begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (hs_s) begin
`ifdef ENCODER_ROUND_ROBIN_EN
          ptr_d = idx_q;
`endif
          if (avail_s != 8'h00) begin
            // Back-to-back grant in the same edge as the acceptance.
            state_d = ST_HOLD;
            valid_d = 1'b1;
            idx_d   = win_hold_s;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end else begin
          // Backpressure: idx and valid held stable.
          state_d = ST_HOLD;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      pending_q <= 8'h00;
`ifdef ENCODER_ROUND_ROBIN_EN
      ptr_q     <= 3'b111;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
`ifdef ENCODER_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign idx     = idx_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_encoder_8to3_pending.sv
// Self-checking bench for encoder_8to3_pending: a cycle table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_encoder_8to3_pending;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic [2:0] idx;
  logic       valid;
  logic       ready;
  logic [7:0] pending;

  int n_tests;
  int n_fail;

  encoder_8to3_pending dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .req     (req),
    .idx     (idx),
    .valid   (valid),
    .ready   (ready),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       rdy;
    logic       ev;   // expected valid after the edge
    logic       ci;   // compare idx on this row
    logic [2:0] ei;   // expected idx
    logic [7:0] ep;   // expected pending
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(logic r, logic e, logic [7:0] q, logic y,
                              logic v, logic c, logic [2:0] i, logic [7:0] p);
    vec_t t;
    t.rst_n = r; t.en = e; t.req = q; t.rdy = y;
    t.ev = v; t.ci = c; t.ei = i; t.ep = p;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the rising edge, settle 1 time unit.
  task automatic step(input logic r, input logic e, input logic [7:0] q, input logic y);
    rst_n  = r;
    enable = e;
    req    = q;
    ready  = y;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int m_pend;
  int m_v;
  int m_idx;
`ifdef ENCODER_ROUND_ROBIN_EN
  int m_ptr;
`endif

  // First set bit of a, looking at positions start, start+1, ... mod 8.
  function automatic int first_from(int a, int start);
    for (int k = 0; k < 8; k++) begin
      if (((a >> ((start + k) % 8)) & 1) == 1) return (start + k) % 8;
    end
    return 0;
  endfunction

  task automatic model_step(input int r, input int e, input int q, input int y);
    int hs;
    int avail;
    int st;
    if (r == 0) begin
      m_pend = 0; m_v = 0; m_idx = 0;
`ifdef ENCODER_ROUND_ROBIN_EN
      m_ptr = 7;
`endif
    end else begin
      hs    = (m_v == 1 && y == 1) ? 1 : 0;
      avail = hs ? (m_pend & ~(1 << m_idx)) : m_pend;
      if (m_v == 0) begin
        if (m_pend != 0) begin
`ifdef ENCODER_ROUND_ROBIN_EN
          st = (m_ptr + 1) % 8;
`else
          st = 0;
`endif
          m_v   = 1;
          m_idx = first_from(m_pend, st);
        end
      end else if (hs == 1) begin
`ifdef ENCODER_ROUND_ROBIN_EN
        m_ptr = m_idx;
        st    = (m_idx + 1) % 8;
`else
        st    = 0;
`endif
        if (avail != 0) m_idx = first_from(avail, st);
        else m_v = 0;
      end
      m_pend = (avail | (e ? q : 0)) & 255;
    end
  endtask

  logic [2:0] exp_seq[4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; enable = 1'b0; req = 8'h00; ready = 1'b0;

    //            rst   en    req    rdy   ev    ci    idx    pending
    tbl[0]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
    tbl[1]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
    tbl[2]  = mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    tbl[3]  = mk(1'b1, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 3'd0, 8'h20);
    tbl[4]  = mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd5, 8'h20);
    tbl[5]  = mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    tbl[6]  = mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    tbl[7]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
    tbl[8]  = mk(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 3'd0, 8'hA5);
    tbl[9]  = mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 8'hA5);
    tbl[10] = mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 8'hA4);
    tbl[11] = mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd5, 8'hA0);
    tbl[12] = mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80);
    tbl[13] = mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    tbl[14] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
    tbl[15] = mk(1'b1, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 3'd0, 8'h0C);
    tbl[16] = mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h0C);
    tbl[17] = mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h0C);
    tbl[18] = mk(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 3'd2, 8'h0C);
    tbl[19] = mk(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 3'd2, 8'h0C);
    tbl[20] = mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h0C);
    tbl[21] = mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08);
    tbl[22] = mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    tbl[23] = mk(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    tbl[24] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
    tbl[25] = mk(1'b1, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 3'd0, 8'h06);
    tbl[26] = mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 8'h06);
    tbl[27] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].rst_n, tbl[i].en, tbl[i].req, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].ep));
      if (tbl[i].ci) chk($sformatf("tbl%0d_idx", i), 32'(idx), 32'(tbl[i].ei));
    end

    // Re-request on accept: bit 4 must survive its own handshake.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h10, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    chk("rereq_valid0", 32'(valid), 32'd1);
    chk("rereq_idx0", 32'(idx), 32'd4);
    step(1'b1, 1'b1, 8'h10, 1'b1);
    chk("rereq_pending_kept", 32'(pending), 32'h10);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    chk("rereq_valid1", 32'(valid), 32'd1);
    chk("rereq_idx1", 32'(idx), 32'd4);
    chk("rereq_pending1", 32'(pending), 32'h10);

    // Burst after a prior grant of 5.
`ifdef ENCODER_ROUND_ROBIN_EN
    exp_seq = '{3'd7, 3'd0, 3'd2, 3'd5};
`else
    exp_seq = '{3'd0, 3'd2, 3'd5, 3'd7};
`endif
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h20, 1'b1);
    step(1'b1, 1'b1, 8'h00, 1'b1);
    chk("prior5_idx", 32'(idx), 32'd5);
    step(1'b1, 1'b1, 8'h00, 1'b1);
    chk("prior5_drop", 32'(valid), 32'd0);
    step(1'b1, 1'b1, 8'hA5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 8'h00, 1'b1);
      chk($sformatf("prior5_seq%0d_valid", k), 32'(valid), 32'd1);
      chk($sformatf("prior5_seq%0d_idx", k), 32'(idx), 32'(exp_seq[k]));
    end
    step(1'b1, 1'b1, 8'h00, 1'b1);
    chk("prior5_end", 32'(valid), 32'd0);

    // Randomized traffic against the model.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    model_step(0, 1, 0, 0);
    for (int c = 0; c < 2000; c++) begin
      logic       r;
      logic       e;
      logic [7:0] q;
      logic       y;
      r = ($urandom_range(0, 49) != 0);
      e = ($urandom_range(0, 3) != 0);
      q = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      y = ($urandom_range(0, 2) != 0);
      model_step(int'(r), int'(e), int'(q), int'(y));
      step(r, e, q, y);
      chk("rand_valid", 32'(valid), 32'(m_v));
      chk("rand_pending", 32'(pending), 32'(m_pend));
      if (m_v == 1) chk("rand_idx", 32'(idx), 32'(m_idx));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
